// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states, word-length codes and the
// 11-bit received-character record stored by the receive FIFO.
package uart_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;

   localparam logic [1:0] WLS_5 = 2'd0;
   localparam logic [1:0] WLS_6 = 2'd1;
   localparam logic [1:0] WLS_7 = 2'd2;
   localparam logic [1:0] WLS_8 = 2'd3;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BRK_WAIT
   } rx_state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       bi;
   } rx_char_t;

   // Parity bit the line should carry; data is zero-filled above the word
   // length, so reducing over all 8 bits is correct for every length.
   function automatic logic rx_exp_parity(input logic [7:0] d, input logic eps,
                                          input logic sp);
      if (sp) return ~eps;
      return eps ? ^d : ~^d;
   endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// N-stage single-bit synchronizer with a configurable reset level; used for
// the receive line and the modem-status inputs.
module uart_sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversamples the synchronized line, recovers
// start/data/parity/stop, and hands one character plus PE/FE/BI to the
// receive FIFO over a valid/ready handshake, flagging overruns.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       baud_en,
   input  logic       sRX,
   input  logic       loopback,
   input  logic       lb_sin,
   input  logic [1:0] lcr_wls,
   input  logic       lcr_pen,
   input  logic       lcr_eps,
   input  logic       lcr_sp,
   output logic [7:0] rx_data,
   output logic       rx_pe,
   output logic       rx_fe,
   output logic       rx_bi,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE/2 - 1);
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   logic       rx_line, rxs;

   rx_state_e  state_q;
   logic [3:0] tick_q;
   logic [2:0] idx_q;
   logic [1:0] wls_q;
   logic       pen_q, eps_q, sp_q;
   logic [7:0] data_q;
   logic       par_q;
   logic       pe_q;

   logic       mid_tick, frame_done, brk_d;
   logic [2:0] last_idx;
   rx_char_t   char_d, char_q;
   logic       valid_q, ovr_q;

   // Loopback selects the internal transmitter before synchronization so
   // both sources see identical sampling behaviour.
   assign rx_line = loopback ? lb_sin : sRX;

   uart_sync_bit #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(1'b1)
   ) u_sync (
      .clk_i (PCLK),
      .rst_ni(PRESETn),
      .d_i   (rx_line),
      .q_o   (rxs)
   );

   assign mid_tick   = baud_en && (tick_q == TICK_MID);
   assign frame_done = mid_tick && (state_q == RX_STOP);
   assign last_idx   = 3'd4 + {1'b0, wls_q};
   // Break: every data bit, the parity bit (cleared when disabled) and the
   // first stop bit all read low.
   assign brk_d      = (data_q == 8'h00) && !par_q && !rxs;

   // Character record presented on the completing edge.
   always_comb begin
      char_d      = '0;
      char_d.data = data_q;
      char_d.pe   = pe_q;
      char_d.fe   = ~rxs;
      char_d.bi   = brk_d;
   end

   // Deframing FSM; advances only on baud ticks, samples at mid-bit.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= RX_IDLE;
         tick_q  <= '0;
         idx_q   <= '0;
         wls_q   <= WLS_5;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         sp_q    <= 1'b0;
         data_q  <= '0;
         par_q   <= 1'b0;
         pe_q    <= 1'b0;
      end else if (baud_en) begin
         tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 4'd1;
         unique case (state_q)
            RX_IDLE: begin
               if (!rxs) begin
                  // Frame format is frozen for the whole frame.
                  tick_q  <= '0;
                  wls_q   <= lcr_wls;
                  pen_q   <= lcr_pen;
                  eps_q   <= lcr_eps;
                  sp_q    <= lcr_sp;
                  data_q  <= '0;
                  par_q   <= 1'b0;
                  pe_q    <= 1'b0;
                  idx_q   <= '0;
                  state_q <= RX_START;
               end
            end
            RX_START: begin
               if (tick_q == TICK_MID) begin
                  if (rxs) state_q <= RX_IDLE;
                  else begin
                     idx_q   <= '0;
                     state_q <= RX_DATA;
                  end
               end
            end
            RX_DATA: begin
               if (tick_q == TICK_MID) begin
                  data_q[idx_q] <= rxs;
                  if (idx_q == last_idx) state_q <= pen_q ? RX_PARITY : RX_STOP;
                  else                   idx_q   <= idx_q + 3'd1;
               end
            end
            RX_PARITY: begin
               if (tick_q == TICK_MID) begin
                  par_q   <= rxs;
                  pe_q    <= (rxs != rx_exp_parity(data_q, eps_q, sp_q));
                  state_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               // A non-break framing error returns to IDLE so a still-low
               // line is re-taken as a start bit.
               if (tick_q == TICK_MID) state_q <= brk_d ? RX_BRK_WAIT : RX_IDLE;
            end
            RX_BRK_WAIT: begin
               if (rxs) state_q <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   // Output holding register with handshake and overrun detection; an
   // accept on the completing edge frees the slot for the new character.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         char_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (frame_done) begin
            if (!valid_q || rx_ready) begin
               char_q  <= char_d;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_data    = char_q.data;
   assign rx_pe      = char_q.pe;
   assign rx_fe      = char_q.fe;
   assign rx_bi      = char_q.bi;
   assign rx_valid   = valid_q;
   assign rx_overrun = ovr_q;
   assign rx_busy    = (state_q != RX_IDLE);

endmodule
